// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-unit control, memory and decode handshake bundle
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_take;
  logic [WIDTH-1:0] branch_target;
  logic             flush;
  logic [WIDTH-1:0] flush_target;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic             inst_valid;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_accept;
  modport master (
    input  stall, branch_take, branch_target, flush, flush_target,
           mem_ready, mem_rdata, inst_accept,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );
  modport slave (
    output stall, branch_take, branch_target, flush, flush_target,
           mem_ready, mem_rdata, inst_accept,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC holder and fetch sequencer with valid/accept handoff to decode
module pc_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               STEP     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_unit_if.master   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [WIDTH-1:0] MASK = ~(WIDTH'(STEP - 1));
  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  // next PC: branch target or sequential step, aligned to STEP
  always_comb npc = (bus.branch_take ? bus.branch_target : pc + WIDTH'(STEP)) & MASK;
  // fetch FSM; flush overrides every other event in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC & MASK;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.inst_valid <= 1'b0;
      bus.inst       <= '0;
      bus.inst_pc    <= '0;
    end else if (bus.flush) begin
      state          <= IDLE;
      pc             <= bus.flush_target & MASK;
      bus.mem_req    <= 1'b0;
      bus.inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!bus.stall) begin
          bus.mem_req  <= 1'b1;
          bus.mem_addr <= pc;
          state        <= REQ;
        end
        REQ: if (bus.mem_ready) begin
          bus.inst       <= bus.mem_rdata;
          bus.inst_pc    <= pc;
          bus.inst_valid <= 1'b1;
          bus.mem_req    <= 1'b0;
          state          <= HOLD;
        end
        HOLD: if (bus.inst_accept) begin
          pc             <= npc;
          bus.inst_valid <= 1'b0;
          bus.mem_req    <= !bus.stall;
          if (!bus.stall) bus.mem_addr <= npc;
          state          <= bus.stall ? IDLE : REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
